sum_sweep_ctrl: RTL and testbench
=================================

# sum_sweep_ctrl

Sequential sweep controller that sits directly upstream of the combinational sum-of-first-N unit (`sumofNnum`). On a start pulse it drives N from `n_lo` to `n_hi` into that unit, one value per cycle. Each returned sum is captured with its N in a 2-entry output buffer, and the buffer drains to a downstream consumer over a valid/ready handshake. It turns the combinational summer into a streaming, back-pressurable stage.

## Interface
Parameters:
- `NW`, 4: width of N.
- `SW`, 7: width of the sum. Must be ≥ 2·NW−1 so that the sum for N = 2^NW−1 (120 at default) is exact.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: one-cycle request to begin a sweep.
- `n_lo` input, NW: first N. Sampled with `start`.
- `n_hi` input, NW: last N, inclusive. Sampled with `start`.
- `n_out` output, NW: N driven to the summer's N input.
- `s_in` input, SW: summer's S output. Combinational function of `n_out`.
- `res_valid` output, 1: a result is available.
- `res_ready` input, 1: the consumer accepts the result.
- `res_n` output, NW: N of the head result.
- `res_s` output, SW: sum of the head result.
- `busy` output, 1: high in RUN and DRAIN.
- `done` output, 1: one-cycle pulse at sweep end.
- `err_cnt` output, 8: checker mismatch count. See Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE (also reached from DONE): on `start`, latch `n_lo` and `n_hi`.
  - If `n_lo` ≤ `n_hi`: set `n_out` = `n_lo` and go to RUN.
  - If `n_lo` > `n_hi`: go straight to DONE. The sweep is empty and no results are produced.
- RUN: each cycle where the buffer is not full, push {`n_out`, `s_in`}.
  - If `n_out` == `n_hi`, go to DRAIN. Otherwise increment `n_out`.
  - Termination is by equality compare before increment, so `n_hi` = 2^NW−1 never wraps.
- RUN with the buffer full: no push, and `n_out` holds.
- DRAIN: wait until the buffer is empty, then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored in RUN and DRAIN.
- `start` is honoured in the DONE cycle, which allows back-to-back sweeps.
- Buffer: 2-entry FIFO, with simultaneous push and pop allowed.
  - When full, a same-cycle pop does not free a slot for a push. Push is gated on not-full only, with no ready pass-through.
  - `res_*` show the head entry. Pop occurs when `res_valid` & `res_ready`.
- Arithmetic: the block performs no sum arithmetic. `s_in` is captured verbatim, SW bits.

## Timing
- Reset values (async assert, all outputs): `n_out` = 0, `res_valid` = 0, `res_n` = 0, `res_s` = 0, `busy` = 0, `done` = 0, `err_cnt` = 0. FSM = IDLE, buffer empty.
- Reset mid-sweep: everything aborts immediately. No `done` pulse and no residual results.
- Start to first result: `start` sampled at edge k; RUN, first push at edge k+1; `res_valid` = 1 after edge k+1.
- Throughput: with `res_ready` held at 1, one result per cycle.
- A sweep of M values with no stall: `done` is high in cycle k+M+2.
- Empty sweep (`n_lo` > `n_hi`): `done` is high in the cycle after the `start` edge. `busy` stays 0.
- `s_in` must settle within the same cycle as `n_out`. The summer is purely combinational.

## Configuration
- Macro `SUM_SWEEP_CHECK_EN`.
- Defined: on every push, the block compares `s_in` against an internal reference n·(n+1)/2 computed at SW bits. Each mismatch increments `err_cnt`, which saturates at 255 and clears on reset or `start`.
- Undefined: no checker logic, and `err_cnt` is tied to 0.

## Structure
- Shared package/header holds:
  - The FSM state encoding (IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3).
  - Default NW and SW.
  - The `err_cnt` width (8).
- One sub-module: `sum_sweep_fifo`. Parameterised width NW+SW, 2 entries, push/pop/full/empty. It is instantiated once for the output buffer.

## Test plan
- Sweep `n_lo` = 1, `n_hi` = 4, `res_ready` = 1: results (1,1), (2,3), (3,6), (4,10) on consecutive cycles; `done` one cycle after the last result drains; `err_cnt` = 0.
- Sweep 0..15 with `res_ready` toggled 1/0 every cycle: all 16 results in order, the last being (15,120); no loss or duplication; `n_out` never wraps past 15.
- `res_ready` = 0 throughout a sweep of 3..9: exactly 2 entries buffered and `n_out` stalls at 5; releasing `res_ready` drains (3,6)…(9,45).
- `n_lo` = 7, `n_hi` = 2: no `res_valid`; `busy` stays 0; `done` pulses once.
- Reset asserted mid-sweep at N = 6: all outputs at reset values immediately; a subsequent start with 2..2 yields only (2,3).
- With `SUM_SWEEP_CHECK_EN` defined, force `s_in` to 0 for a sweep of 1..3: `err_cnt` = 3; the next `start` clears it to 0.

Source files
------------

// File: rtl/sum_sweep_ctrl_pkg.sv
// Shared definitions for the sum sweep controller: FSM encoding,
// default widths and the checker counter width.
package sum_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NW_DEF = 4;
    localparam int SW_DEF = 7;
    localparam int ERR_W  = 8;

endpackage

// File: rtl/sum_sweep_fifo.sv
// Two-entry FIFO holding {n, sum} results; head is shown combinationally.
// Push is dropped when full, pop is dropped when empty.
module sum_sweep_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= data;
                wp      <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/sum_sweep_ctrl.sv
// Sweeps N from n_lo to n_hi into a combinational summer and streams
// {N, sum} out through a 2-entry buffer. Optional checker: SUM_SWEEP_CHECK_EN.
module sum_sweep_ctrl
    import sum_sweep_ctrl_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NW-1:0]    n_lo,
    input  logic [NW-1:0]    n_hi,
    output logic [NW-1:0]    n_out,
    input  logic [SW-1:0]    s_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NW-1:0]    res_n,
    output logic [SW-1:0]    res_s,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    state_t        state;
    state_t        state_nx;
    logic [NW-1:0] n_out_nx;
    logic [NW-1:0] hi_q;
    logic [NW-1:0] hi_nx;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [1:0]    cnt;

    assign accept    = start && (state == IDLE || state == DONE);
    assign push      = (state == RUN) && !full;
    assign res_valid = !empty;
    assign pop       = res_valid && res_ready;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n_out <= '0;
            hi_q  <= '0;
        end else begin
            state <= state_nx;
            n_out <= n_out_nx;
            hi_q  <= hi_nx;
        end
    end

    always_comb begin
        state_nx = state;
        n_out_nx = n_out;
        hi_nx    = hi_q;
        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    state_nx = IDLE;
                end
                if (start) begin
                    hi_nx = n_hi;
                    if (n_lo <= n_hi) begin
                        n_out_nx = n_lo;
                        state_nx = RUN;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            RUN: begin
                // compare before increment so n_hi = max never wraps
                if (!full) begin
                    if (n_out == hi_q) begin
                        state_nx = DRAIN;
                    end else begin
                        n_out_nx = n_out + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (empty || (cnt == 2'd1 && pop)) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    sum_sweep_fifo #(
        .W(NW + SW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .data ({n_out, s_in}),
        .head ({res_n, res_s}),
        .full (full),
        .empty(empty),
        .cnt  (cnt)
    );

`ifdef SUM_SWEEP_CHECK_EN
    logic [2*NW-1:0] prod;
    logic [SW-1:0]   ref_s;

    assign prod  = (2*NW)'(n_out) * ((2*NW)'(n_out) + 1'b1);
    assign ref_s = SW'(prod >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (push && s_in != ref_s && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sum_sweep_ctrl.sv
// Scoreboard bench for sum_sweep_ctrl with a behavioural summer model
// and randomized sweeps / back-pressure.
module tb_sum_sweep_ctrl;

    localparam int NW = 4;
    localparam int SW = 7;

    typedef struct {
        int n;
        int s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n_lo = '0;
    logic [NW-1:0] n_hi = '0;
    logic [NW-1:0] n_out;
    logic [SW-1:0] s_in;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [NW-1:0] res_n;
    logic [SW-1:0] res_s;
    logic          busy;
    logic          done;
    logic [7:0]    err_cnt;

    bit   force_zero = 1'b0;
    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_pop = -10;
    int   done_cnt = 0;
    bit   prev_done = 1'b0;
    bit   nonempty = 1'b0;
    int   cur_hi = 15;
    int   rmode = 0;

    function automatic int tri_sum(int n);
        return n * (n + 1) / 2;
    endfunction

    assign s_in = force_zero ? '0 : SW'(tri_sum(int'(n_out)));

    always #5 clk = ~clk;

    sum_sweep_ctrl #(
        .NW(NW),
        .SW(SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_lo     (n_lo),
        .n_hi     (n_hi),
        .n_out    (n_out),
        .s_in     (s_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_n    (res_n),
        .res_s    (res_s),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       res_ready = 1'b1;
            1:       res_ready = ~res_ready;
            2:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
    end

    // monitor: every handshake pops the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", int'(res_n), -1);
                end else begin
                    e = q.pop_front();
                    chk("res_n", int'(res_n), e.n);
                    chk("res_s", int'(res_s), e.s);
                end
                last_pop = cyc;
            end
            if (busy) begin
                chk("n_out_le_hi", int'(int'(n_out) <= cur_hi), 1);
            end
            if (done) begin
                chk("done_single_cycle", int'(prev_done), 0);
                chk("done_all_drained", q.size(), 0);
                if (nonempty) begin
                    chk("done_after_last_pop", cyc - last_pop, 1);
                end
                done_cnt++;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic do_sweep(input int lo, input int hi, input int mode, input bit stall);
        int d0;
        int k;
        d0       = done_cnt;
        rmode    = stall ? 3 : mode;
        cur_hi   = hi;
        nonempty = (lo <= hi);
        @(posedge clk);
        #1;
        start = 1'b1;
        n_lo  = NW'(lo);
        n_hi  = NW'(hi);
        for (int n = lo; n <= hi; n++) begin
            q.push_back('{n: n, s: (force_zero ? 0 : tri_sum(n))});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (stall) begin
            repeat (8) @(negedge clk);
            #1;
            chk("stall_n_out", int'(n_out), lo + 2);
            chk("stall_valid", int'(res_valid), 1);
            chk("stall_head_n", int'(res_n), lo);
            chk("stall_busy", int'(busy), 1);
            rmode = 0;
        end
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
            if (!nonempty) begin
                chk("empty_busy", int'(busy), 0);
                chk("empty_valid", int'(res_valid), 0);
            end
        end
        if (done_cnt == d0) begin
            chk("done_timeout", 0, 1);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_not_busy", int'(busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_n_out"}, int'(n_out), 0);
        chk({tag, "_valid"}, int'(res_valid), 0);
        chk({tag, "_res_n"}, int'(res_n), 0);
        chk({tag, "_res_s"}, int'(res_s), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        int hi;
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_sweep(1, 4, 0, 1'b0);
        chk("err_clean", int'(err_cnt), 0);
        do_sweep(0, 15, 1, 1'b0);
        do_sweep(3, 9, 0, 1'b1);
        do_sweep(7, 2, 0, 1'b0);
        do_sweep(15, 15, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            lo = int'($urandom_range(0, 15));
            hi = int'($urandom_range(0, 15));
            do_sweep(lo, hi, 2, 1'b0);
        end

        // abort a sweep when n_out reaches 6
        rmode    = 1;
        cur_hi   = 15;
        nonempty = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        n_lo  = 4'd0;
        n_hi  = 4'd15;
        for (int n = 0; n <= 15; n++) begin
            q.push_back('{n: n, s: tri_sum(n)});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (n_out != 4'd6 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_n6", int'(n_out), 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_sweep(2, 2, 0, 1'b0);

`ifdef SUM_SWEEP_CHECK_EN
        force_zero = 1'b1;
        do_sweep(1, 3, 0, 1'b0);
        chk("err_cnt_three", int'(err_cnt), 3);
        force_zero = 1'b0;
        do_sweep(2, 2, 0, 1'b0);
        chk("err_cnt_cleared", int'(err_cnt), 0);
`else
        chk("err_cnt_tied", int'(err_cnt), 0);
`endif

        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
